// File: rtl/gol_pkg.sv
// Shared definitions for the Game-of-Life engine: FSM state encoding and
// the (row, col) -> flat grid bit mapping used by every grid consumer.
package gol_pkg;

  // Engine control states, kept as plain 2-bit constants so older blocks
  // that compare against raw codes keep working.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_HALT = 2'd2;

  // Row 0 is the most-significant row; column 0 is the MS bit of its row.
  function automatic int cell_index(input int r, input int c,
                                    input int rows, input int cols);
    return (rows * cols - 1) - (r * cols + c);
  endfunction

endpackage

// File: rtl/gol_next.sv
// Combinational B3/S23 next-generation logic for a ROWS x COLS grid.
// WRAP=0 treats everything outside the grid as dead, WRAP=1 is toroidal.
module gol_next
  import gol_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int WRAP = 0
) (
  input  logic [ROWS*COLS-1:0] i_grid,
  output logic [ROWS*COLS-1:0] o_next
);

  // Live-neighbour count of cell (r, c); 8 neighbours fit in 4 bits.
  function automatic logic [3:0] live_nbrs(input logic [ROWS*COLS-1:0] g,
                                           input int r, input int c);
    logic [3:0] n;
    int rr;
    int cc;
    n = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr;
        cc = c + dc;
        if (!(dr == 0 && dc == 0)) begin
          if (WRAP != 0) begin
            rr = (rr + ROWS) % ROWS;
            cc = (cc + COLS) % COLS;
          end
          if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS)
            n = n + {3'd0, g[cell_index(rr, cc, ROWS, COLS)]};
        end
      end
    end
    return n;
  endfunction

  // Apply survive-on-2/3, born-on-3 to every cell.
  always_comb begin
    logic [3:0] w_n;
    logic       w_cur;
    o_next = '0;
    w_n    = '0;
    w_cur  = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        w_n   = live_nbrs(i_grid, r, c);
        w_cur = i_grid[cell_index(r, c, ROWS, COLS)];
        o_next[cell_index(r, c, ROWS, COLS)] =
          (w_n == 4'd3) || (w_cur && (w_n == 4'd2));
      end
    end
  end

endmodule

// File: rtl/gol_engine.sv
// Game-of-Life engine: grid register, IDLE/RUN/HALT control, generation
// counter and sticky stable/extinct/done flags. One generation per clock.
module gol_engine
  import gol_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int WRAP  = 0,
  parameter int GEN_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [ROWS*COLS-1:0] seed,
  input  logic                 run,
  input  logic                 step,
  input  logic [GEN_W-1:0]     max_gen,
  output logic [ROWS*COLS-1:0] grid,
  output logic [GEN_W-1:0]     gen_count,
  output logic                 busy,
  output logic                 stable,
  output logic                 extinct,
  output logic                 done,
  output logic [1:0]           dbg_state
);

  localparam logic [GEN_W-1:0] CNT_MAX = '1;

  logic [ROWS*COLS-1:0] r_grid;
  logic [GEN_W-1:0]     r_gen_count;
  state_t               r_state;
  logic                 r_stable;
  logic                 r_extinct;
  logic                 r_done;

  logic [ROWS*COLS-1:0] w_next;
  logic                 w_same;
  logic                 w_empty;
  logic [GEN_W-1:0]     w_inc;
  logic [GEN_W-1:0]     w_cnt_next;
  logic                 w_limit;

  gol_next #(.ROWS(ROWS), .COLS(COLS), .WRAP(WRAP)) u_next (
    .i_grid (r_grid),
    .o_next (w_next)
  );

  // Stability/extinction tests and the saturating counter increment.
  always_comb begin
    w_same     = (w_next == r_grid);
    w_empty    = (r_grid == '0);
    w_inc      = r_gen_count + GEN_W'(1);
    w_cnt_next = (r_gen_count == CNT_MAX) ? r_gen_count : w_inc;
    // w_inc wraps to 0 at saturation, which never equals a nonzero limit.
    w_limit    = (max_gen != '0) && (w_inc == max_gen);
  end

  // Control FSM and datapath; load overrides everything except reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grid      <= '0;
      r_gen_count <= '0;
      r_state     <= ST_IDLE;
      r_stable    <= 1'b0;
      r_extinct   <= 1'b0;
      r_done      <= 1'b0;
    end else if (load) begin
      r_grid      <= seed;
      r_gen_count <= '0;
      r_state     <= ST_IDLE;
      r_stable    <= 1'b0;
      r_extinct   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // run wins over step; the transition cycle commits nothing.
          if (run) begin
            r_state <= ST_RUN;
          end else if (step) begin
            r_grid      <= w_next;
            r_gen_count <= w_cnt_next;
            r_stable    <= w_same;
            r_extinct   <= w_same && w_empty;
          end
        end
        ST_RUN: begin
          if (!run) begin
            r_state <= ST_IDLE;
          end else if (w_same) begin
            r_stable  <= 1'b1;
            r_extinct <= w_empty;
            r_state   <= ST_HALT;
          end else begin
            r_grid      <= w_next;
            r_gen_count <= w_cnt_next;
            if (w_limit) begin
              r_done  <= 1'b1;
              r_state <= ST_HALT;
            end
          end
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign grid      = r_grid;
  assign gen_count = r_gen_count;
  assign busy      = (r_state == ST_RUN);
  assign stable    = r_stable;
  assign extinct   = r_extinct;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: doc/gol_engine.md
Name: gol_engine

Overview:
Parametrised Conway Game-of-Life engine. Holds a ROWS x COLS cell grid in a register and computes one B3/S23 generation per clock.
- Adds seed load, free-run and single-step control, toroidal or dead-edge boundaries, a generation counter, and stability/extinction/generation-limit halting.
- Sits between the seed/control logic (switch or FSM front end) and the display driver, which reads grid directly.

Parameters:
ROWS, 8, grid height in cells (>=3)
COLS, 8, grid width in cells (>=3)
WRAP, 0, 0 = cells outside grid are dead; 1 = toroidal wrap-around on both axes
GEN_W, 16, width of generation counter and max_gen

Ports:
clk  in  1  clock, rising edge
reset  in  1  reset, asynchronous, active-high
load  in  1  load seed into grid (level, sampled each edge)
seed  in  ROWS*COLS  initial grid pattern
run  in  1  free-run enable (level)
step  in  1  single-generation request (one-cycle pulse)
max_gen  in  GEN_W  halt after this many generations; 0 = unlimited
grid  out  ROWS*COLS  current generation
gen_count  out  GEN_W  generations computed since last load
busy  out  1  high while in RUN
stable  out  1  sticky: next generation equals current
extinct  out  1  sticky: grid all zero when stability detected
done  out  1  sticky: max_gen reached

Behaviour:
- Cell (r,c) maps to bit (ROWS*COLS-1)-(r*COLS+c): row 0 is the MS row, col 0 the MS bit of each row.
- Next state per cell: live neighbours n over 8 neighbours. Live cell survives if n = 2 or 3. Dead cell is born if n = 3. Otherwise the cell is dead. Neighbour count is 4 bits.
- WRAP=0: out-of-range neighbours count as dead. WRAP=1: indices taken mod ROWS / mod COLS.
- Next generation is computed combinationally from grid. The grid register updates one edge after the command, so latency is 1 cycle per generation.
- Reset (async): grid = 0, gen_count = 0, stable = extinct = done = 0, state IDLE, busy = 0.

State machine (IDLE, RUN, HALT):
- load (any state, highest priority):
  - grid <= seed, gen_count <= 0, stable/extinct/done <= 0, state <= IDLE.
  - run and step are ignored in that cycle.
- IDLE:
  - step=1: grid <= next, gen_count++. stable <= (next==grid). extinct <= stable condition and grid==0. Stay IDLE.
  - run=1: go to RUN; no update in that transition cycle.
  - run and step both high: run wins.
- RUN, evaluated in priority order each cycle:
  1. run=0 -> IDLE, no update.
  2. next==grid -> stable <= 1, extinct <= (grid==0), HALT. grid and gen_count unchanged.
  3. Otherwise grid <= next, gen_count++. If max_gen!=0 and gen_count+1==max_gen: done <= 1, HALT.
- HALT:
  - grid and gen_count frozen; run and step ignored.
  - Leave only via load or reset.
- gen_count saturates at all-ones (no wrap). Saturation does not halt.
- busy = (state==RUN), registered-state decode.
- Reset mid-run: takes effect immediately and asynchronously; no partial generation committed.

Decomposition:
- Package gol_pkg: state typedef (IDLE, RUN, HALT) and a cell_index(r,c) helper function.
- One sub-module gol_next: purely combinational, parametrised ROWS/COLS/WRAP, grid in, next grid out.
- gol_engine holds the FSM, grid register, counter and flags.

Test Plan:
1. Glider, 8x8, WRAP=0: load 64'h4020_E000_0000_0000, step x4 -> grid 64'h0020_1070_0000_0000, gen_count=4, stable=0.
2. Glider, WRAP=1: same seed, run with max_gen=32 -> halts with grid == seed, gen_count=32, done=1, busy falls next cycle.
3. Blinker: load 64'h0070_0000_0000_0000, step -> 64'h2020_2000_0000_0000. Step again -> original. stable stays 0.
4. Block still-life: load 64'h0000_0018_1800_0000, run -> HALT after 1 cycle, gen_count=0, stable=1, extinct=0.
5. Single cell 64'h0000_0000_1000_0000, run -> grid=0 with gen_count=1, then HALT with stable=1, extinct=1.
6. Control edge cases:
   - load asserted during RUN (glider) -> grid=seed, counters and flags cleared, IDLE.
   - reset asserted mid-run between edges -> outputs 0 immediately.
   - run+step together in IDLE -> RUN entered, no step applied.
